// File: rtl/nt_node_pipe_mon_if.sv
// nt_node_pipe_mon_if: channel-input / observe-node-output handshake bundle for nt_node_pipe_mon.
// Ports: in_data/in_valid/in_ready (upstream side), out_node/out_valid/out_ready (downstream side).
// The slave modport is the pipe itself; master is whoever drives inputs and consumes the node.
interface nt_node_pipe_mon_if #(
    parameter int CH = 4
);
    logic [CH-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          out_node;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_node, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_node, out_valid
    );
endinterface

// File: rtl/nt_node_pipe_mon.sv
// nt_node_pipe_mon: CH nets through DEPTH DFF stages, reduced (OR/AND/XOR) into one registered observe node.
// Latency: DEPTH cycles from accept to out_valid; throughput one result per cycle.
// Backpressure: every stage holds while out_valid & !out_ready; in_ready = !out_valid | out_ready.
//
// Ports: I1470_clk (rising edge), I1477_rst (async, active-low), pipe (slave: in_data/in_valid/
//   in_ready, out_node/out_valid/out_ready), act_count, rare_flag, win_done (activity monitor).
// Build option: define ACT_MON_EN to build the windowed activity monitor; otherwise act_count,
//   rare_flag and win_done are tied to 0 and no monitor flops exist.
module nt_node_pipe_mon #(
    parameter int CH     = 4,
    parameter int DEPTH  = 2,
    parameter int MODE   = 0,
    parameter int CNT_W  = 8,
    parameter int WIN_W  = 10,
    parameter int THRESH = 1
) (
    input  logic               I1470_clk,
    input  logic               I1477_rst,
    nt_node_pipe_mon_if.slave  pipe,
    output logic [CNT_W-1:0]   act_count,
    output logic               rare_flag,
    output logic               win_done
);

    // Elaboration-time guard against meaningless configurations.
    if (CH < 1 || DEPTH < 1 || CNT_W < 1 || CNT_W > 32 || WIN_W < 1 || THRESH < 0) begin : g_bad_cfg
        $error("nt_node_pipe_mon: illegal parameter combination");
    end

    logic [CH-1:0]    stg_dat_q [DEPTH];
    logic [DEPTH-1:0] stg_vld_q;
    logic             out_node_q;
    logic             out_node_d;
    logic             out_vld_q;
    logic             advance;

    // The whole pipe moves as one shift register; empty slots are not squeezed out.
    assign advance        = !out_vld_q || pipe.out_ready;
    assign pipe.in_ready  = advance;
    assign pipe.out_node  = out_node_q;
    assign pipe.out_valid = out_vld_q;

    always_comb begin
        out_node_d = |stg_dat_q[DEPTH-1];
        case (MODE)
            1:       out_node_d = &stg_dat_q[DEPTH-1];
            2:       out_node_d = ^stg_dat_q[DEPTH-1];
            default: out_node_d = |stg_dat_q[DEPTH-1];
        endcase
    end

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_dat_q[i] <= '0;
            end
            stg_vld_q  <= '0;
            out_node_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else if (advance) begin
            stg_dat_q[0] <= pipe.in_data;
            stg_vld_q[0] <= pipe.in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stg_dat_q[i] <= stg_dat_q[i-1];
                stg_vld_q[i] <= stg_vld_q[i-1];
            end
            out_node_q <= out_node_d;
            out_vld_q  <= stg_vld_q[DEPTH-1];
        end
    end

`ifdef ACT_MON_EN
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;
    logic [CNT_W-1:0] act_q;
    logic [CNT_W-1:0] act_d;
    logic [CNT_W-1:0] act_sum;
    logic             rare_q;
    logic             rare_d;
    logic             hit_ev;
    logic             win_end;

    always_comb begin
        // A node==1 result consumed downstream this cycle.
        hit_ev  = out_vld_q && pipe.out_ready && out_node_q;
        win_end = (win_q == '1);
        act_sum = act_q;
        if (hit_ev && (act_q != '1)) begin
            act_sum = act_q + CNT_W'(1);
        end
        win_d  = win_q + WIN_W'(1);
        act_d  = act_sum;
        rare_d = rare_q;
        // The closing window includes an event landing on its very last cycle.
        if (win_end) begin
            act_d  = '0;
            rare_d = (32'(act_sum) < 32'(THRESH));
        end
    end

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            win_q  <= '0;
            act_q  <= '0;
            rare_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            act_q  <= act_d;
            rare_q <= rare_d;
        end
    end

    assign act_count = act_q;
    assign rare_flag = rare_q;
    assign win_done  = win_end;
`else
    assign act_count = '0;
    assign rare_flag = 1'b0;
    assign win_done  = 1'b0;
`endif

endmodule

// File: tb/tb_nt_node_pipe_mon.sv
// tb_nt_node_pipe_mon: scoreboard bench for three nt_node_pipe_mon instances (OR/AND/XOR) on one stream.
// Stimulus pushes hand-computed per-mode results on accept; a negedge monitor pops on out_valid & out_ready.
// The monitor also tracks the window/activity expectations, or all-zero monitor outputs without ACT_MON_EN.
module tb_nt_node_pipe_mon;
    localparam int CW = 2;
    localparam int WW = 4;
    localparam int TH = 2;
    localparam int WLAST = (1 << WW) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] in_data = 4'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    nt_node_pipe_mon_if #(.CH(4)) if0 ();
    nt_node_pipe_mon_if #(.CH(4)) if1 ();
    nt_node_pipe_mon_if #(.CH(4)) if2 ();

    assign if0.in_data = in_data;  assign if0.in_valid = in_valid;  assign if0.out_ready = out_ready;
    assign if1.in_data = in_data;  assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;
    assign if2.in_data = in_data;  assign if2.in_valid = in_valid;  assign if2.out_ready = out_ready;

    logic [CW-1:0] act0, act1, act2;
    logic          rare0, rare1, rare2;
    logic          win0, win1, win2;

    nt_node_pipe_mon #(.CH(4), .DEPTH(2), .MODE(0), .CNT_W(CW), .WIN_W(WW), .THRESH(TH)) u_or (
        .I1470_clk(clk), .I1477_rst(rst_n), .pipe(if0),
        .act_count(act0), .rare_flag(rare0), .win_done(win0));
    nt_node_pipe_mon #(.CH(4), .DEPTH(2), .MODE(1), .CNT_W(CW), .WIN_W(WW), .THRESH(TH)) u_and (
        .I1470_clk(clk), .I1477_rst(rst_n), .pipe(if1),
        .act_count(act1), .rare_flag(rare1), .win_done(win1));
    nt_node_pipe_mon #(.CH(4), .DEPTH(2), .MODE(2), .CNT_W(CW), .WIN_W(WW), .THRESH(TH)) u_xor (
        .I1470_clk(clk), .I1477_rst(rst_n), .pipe(if2),
        .act_count(act2), .rare_flag(rare2), .win_done(win2));

    int n_tests = 0;
    int n_fail  = 0;
    logic q_or[$];
    logic q_and[$];
    logic q_xor[$];
    int cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of stimulus; entered and left just after a rising edge. v = {data, or, and, xor}.
    task automatic drive(input logic iv, input logic [6:0] v, input logic ordy, output logic acc);
        in_valid  = iv;
        in_data   = v[6:3];
        out_ready = ordy;
        @(negedge clk);
        acc = iv && if0.in_ready;
        @(posedge clk);
        if (acc) begin
            q_or.push_back(v[2]);
            q_and.push_back(v[1]);
            q_xor.push_back(v[0]);
        end
        #1;
    endtask

    task automatic send(input logic [6:0] v, input logic ordy);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            drive(1'b1, v, ordy, acc);
            tries++;
        end
        chk("send_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        drive(1'b0, 7'b0, ordy, acc);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_vld_or"},  32'(if0.out_valid), 32'd0);
        chk({tag, "_vld_and"}, 32'(if1.out_valid), 32'd0);
        chk({tag, "_vld_xor"}, 32'(if2.out_valid), 32'd0);
        chk({tag, "_node"},    32'(if0.out_node),  32'd0);
        chk({tag, "_act"},     32'(act0),          32'd0);
        chk({tag, "_rare"},    32'(rare0),         32'd0);
        chk({tag, "_win"},     32'(win0),          32'd0);
    endtask

`ifdef ACT_MON_EN
    int   m_win;
    int   m_act;
    logic m_rare;
    int   m_nxt;
`endif
    logic ev;
    logic e;

    // Monitor: pops and compares on every consumed output, and checks monitor outputs each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
`ifdef ACT_MON_EN
            m_win  = 0;
            m_act  = 0;
            m_rare = 1'b0;
`endif
        end else begin
`ifdef ACT_MON_EN
            chk("win_done",  32'(win0),  32'(m_win == WLAST));
            chk("act_count", 32'(act0),  32'(m_act));
            chk("rare_flag", 32'(rare0), 32'(m_rare));
`else
            chk("win_done_off",  32'(win0),  32'd0);
            chk("act_count_off", 32'(act0),  32'd0);
            chk("rare_flag_off", 32'(rare0), 32'd0);
`endif
            ev = 1'b0;
            if (if0.out_valid && out_ready) begin
                chk("or_expected_pending", 32'(q_or.size() > 0), 32'd1);
                if (q_or.size() > 0) begin
                    e = q_or.pop_front();
                    chk("node_or", 32'(if0.out_node), 32'(e));
                    ev = e;
                end
            end
            if (if1.out_valid && out_ready) begin
                chk("and_expected_pending", 32'(q_and.size() > 0), 32'd1);
                if (q_and.size() > 0) begin
                    e = q_and.pop_front();
                    chk("node_and", 32'(if1.out_node), 32'(e));
                end
            end
            if (if2.out_valid && out_ready) begin
                chk("xor_expected_pending", 32'(q_xor.size() > 0), 32'd1);
                if (q_xor.size() > 0) begin
                    e = q_xor.pop_front();
                    chk("node_xor", 32'(if2.out_node), 32'(e));
                end
            end
`ifdef ACT_MON_EN
            m_nxt = m_act + int'(ev);
            if (m_nxt > CMAX) m_nxt = CMAX;
            if (m_win == WLAST) begin
                m_rare = (m_nxt < TH);
                m_act  = 0;
            end else begin
                m_act = m_nxt;
            end
            m_win = (m_win + 1) % (WLAST + 1);
`endif
        end
    end

    // {data, or, and, xor}
    logic [6:0] mode_vec [4] = '{7'b1111_110, 7'b1110_101, 7'b0111_101, 7'b0110_100};
    logic [6:0] w1_vec   [4] = '{7'b1111_110, 7'b0000_000, 7'b0110_100, 7'b0111_101};
    logic [6:0] w2_vec   [5] = '{7'b1110_101, 7'b0001_101, 7'b0010_101, 7'b0100_101, 7'b1000_101};

    initial begin
        logic acc;
        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk_zero_outs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency: 0000 then 0100, result two edges after accept
        drive(1'b1, 7'b0000_000, 1'b1, acc);
        chk("lat0_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat0_valid", 32'(if0.out_valid), 32'(k == 2));
            if (k == 2) chk("lat0_node", 32'(if0.out_node), 32'd0);
            @(posedge clk);
            #1;
        end
        drive(1'b1, 7'b0100_101, 1'b1, acc);
        chk("lat1_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat1_valid", 32'(if0.out_valid), 32'(k == 2));
            if (k == 2) chk("lat1_node", 32'(if0.out_node), 32'd1);
            @(posedge clk);
            #1;
        end

        // Merge modes, back to back
        for (int i = 0; i < 4; i++) send(mode_vec[i], 1'b1);
        repeat (4) idle(1'b1);

        // Backpressure: fill three slots, stall five cycles, release
        send(7'b1110_101, 1'b0);
        send(7'b0000_000, 1'b0);
        send(7'b1111_110, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            in_data   = 4'b0110;
            out_ready = 1'b0;
            @(negedge clk);
            chk("stall_in_ready", 32'(if0.in_ready), 32'd0);
            chk("stall_valid",    32'(if0.out_valid), 32'd1);
            chk("stall_node_or",  32'(if0.out_node), 32'(q_or[0]));
            chk("stall_node_and", 32'(if1.out_node), 32'(q_and[0]));
            @(posedge clk);
            #1;
        end
        send(7'b0110_100, 1'b1);
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            @(negedge clk);
            chk("drain_valid", 32'(if0.out_valid), 32'(k < 3));
            @(posedge clk);
            #1;
        end

        // Mid-cycle asynchronous reset with the pipe full
        send(7'b0111_101, 1'b0);
        send(7'b0100_101, 1'b0);
        send(7'b1111_110, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_zero_outs("async_rst");
        q_or.delete();
        q_and.delete();
        q_xor.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Window 0: one hit; window 1: three hits; window 2: five hits; window 3: none
        send(7'b0100_101, 1'b1);
        while (cyc < 16) idle(1'b1);
        for (int i = 0; i < 4; i++) send(w1_vec[i], 1'b1);
        while (cyc < 32) idle(1'b1);
        for (int i = 0; i < 5; i++) send(w2_vec[i], 1'b1);
        while (cyc < 66) idle(1'b1);

        chk("sb_or_empty",  32'(q_or.size()),  32'd0);
        chk("sb_and_empty", 32'(q_and.size()), 32'd0);
        chk("sb_xor_empty", 32'(q_xor.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
